// File: rtl/qft_pipe_scheduler_if.sv
// qft_pipe_scheduler_if
//   Bundles the batch-control, upstream/downstream handshake and status
//   signals of the QFT gate-pipeline scheduler.
//   slave  : the scheduler itself.
//   master : whoever drives batches into the scheduler (controller or bench).
//
// Handshake: a vector moves across a boundary only in a cycle where both
// valid and ready are high. in_valid/out_valid must not depend on the
// corresponding ready. in_ready and pipe_en are combinational in the same
// cycle, and a source may raise valid whenever it likes.
interface qft_pipe_scheduler_if #(
  parameter int NUM_STAGES = 7,
  parameter int BATCH_W    = 8
);
  logic                  start;
  logic [BATCH_W-1:0]    batch_len;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  pipe_en;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic [3:0]            inflight;
  logic [15:0]           stall_cnt;
  logic [1:0]            fsm_state;

  modport slave (
    input  start, batch_len, flush, in_valid, out_ready,
    output in_ready, pipe_en, stage_valid, out_valid, busy, done,
           inflight, stall_cnt, fsm_state
  );

  modport master (
    output start, batch_len, flush, in_valid, out_ready,
    input  in_ready, pipe_en, stage_valid, out_valid, busy, done,
           inflight, stall_cnt, fsm_state
  );
endinterface

// File: rtl/qft_pipe_scheduler.sv
// qft_pipe_scheduler
//   Sequences a batch of state vectors through a NUM_STAGES-deep gate
//   pipeline (H, CP, CP, H, CP, H, SWAP by default). Tracks per-stage
//   occupancy, issues a global advance enable, counts issued/retired
//   vectors and output back-pressure cycles, and pulses done at batch end.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : qft_pipe_scheduler_if.slave
//                start/batch_len/flush   batch control
//                in_valid/in_ready       upstream handshake
//                out_valid/out_ready     downstream handshake
//                pipe_en, stage_valid    pipeline control/occupancy
//                busy, done, inflight,
//                stall_cnt, fsm_state    status and debug
module qft_pipe_scheduler #(
  parameter int NUM_STAGES = 7,
  parameter int BATCH_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  qft_pipe_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] sv_q;
  logic [BATCH_W-1:0]    len_q, issued_q, retired_q, issued_inc;
  logic [15:0]           stall_q;
  logic                  out_valid, pipe_en, in_ready, accept, retire, busy;
  logic [3:0]            pop_cnt;

  assign out_valid  = sv_q[NUM_STAGES-1];
  // A stage advances unless the final stage holds a result nobody takes,
  // so a back-pressure stall freezes the whole pipeline at once.
  assign pipe_en    = !out_valid || bus.out_ready;
  assign in_ready   = (state_q == FILL) && pipe_en && !bus.flush;
  assign accept     = bus.in_valid && in_ready;
  assign retire     = out_valid && bus.out_ready;
  assign busy       = (state_q != IDLE);
  assign issued_inc = issued_q + 1'b1;

  always_comb begin
    pop_cnt = 4'd0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      pop_cnt = pop_cnt + {3'd0, sv_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.batch_len == '0) ? DONE : FILL;
      FILL:  if (accept && (issued_inc == len_q)) state_d = DRAIN;
      DRAIN: if (retired_q == len_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wins over start, accept and retire.
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sv_q      <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      stall_q   <= '0;
    end else if (bus.flush) begin
      state_q   <= IDLE;
      sv_q      <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pipe_en) sv_q <= {sv_q[NUM_STAGES-2:0], accept};
      if ((state_q == IDLE) && bus.start) begin
        len_q     <= bus.batch_len;
        issued_q  <= '0;
        retired_q <= '0;
        stall_q   <= '0;
      end else begin
        if (accept) issued_q  <= issued_inc;
        if (retire) retired_q <= retired_q + 1'b1;
        if (busy && out_valid && !bus.out_ready && (stall_q != 16'hFFFF))
          stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.pipe_en     = pipe_en;
  assign bus.in_ready    = in_ready;
  assign bus.stage_valid = sv_q;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == DONE);
  assign bus.inflight    = pop_cnt;
  assign bus.stall_cnt   = stall_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: doc/qft_pipe_scheduler.md
QFT_PIPE_SCHEDULER -- requirements
Module: qft_pipe_scheduler

Interface
REQ-001 Parameter NUM_STAGES, default 7, SHALL set the number of gate pipeline stages sequenced (H, CP, CP, H, CP, H, SWAP); legal range 2..15.
REQ-002 Parameter BATCH_W, default 8, SHALL set the width of the batch length and batch counters.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a batch; sampled only in IDLE.
REQ-006 batch_len  input  BATCH_W  number of state vectors in the batch; sampled with start.
REQ-007 flush  input  1  synchronous abort of the batch and pipeline contents.
REQ-008 in_valid  input  1  upstream state vector present.
REQ-009 in_ready  output  1  scheduler accepts the upstream vector this cycle.
REQ-010 pipe_en  output  1  global advance enable driven to every gate stage register.
REQ-011 stage_valid  output  NUM_STAGES  per-stage occupancy; bit k SHALL mean stage k holds a valid vector.
REQ-012 out_valid  output  1  final stage holds a result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when the batch completes.
REQ-016 inflight  output  4  number of vectors currently in the pipeline.
REQ-017 stall_cnt  output  16  saturating count of output back-pressure cycles in the current batch.

Function
REQ-018 FSM states SHALL be IDLE, FILL, DRAIN and DONE.
REQ-019 IDLE: start=1 with batch_len>0 SHALL go to FILL; start=1 with batch_len=0 SHALL go to DONE; start SHALL be ignored in other states.
REQ-020 On start, batch_len SHALL be latched, issued/retired counters SHALL be cleared and stall_cnt SHALL be zeroed.
REQ-021 out_valid SHALL equal stage_valid[NUM_STAGES-1].
REQ-022 pipe_en SHALL be combinational: !out_valid || out_ready.
REQ-023 in_ready SHALL be combinational: state==FILL && pipe_en && !flush.
REQ-024 A vector is accepted when in_valid && in_ready; the issued count SHALL increment by 1 on each accept.
REQ-025 When pipe_en=1, stage_valid SHALL shift one place toward the output, with bit 0 loaded with the accept indication; when pipe_en=0, stage_valid SHALL hold.
REQ-026 Latency from accept to out_valid SHALL be exactly NUM_STAGES cycles with no back-pressure.
REQ-027 A retire is out_valid && out_ready; the retired count SHALL increment by 1 on each retire.
REQ-028 inflight SHALL equal the popcount of stage_valid at all times, including a simultaneous accept and retire (net unchanged).
REQ-029 FILL SHALL go to DRAIN in the cycle after the accept that makes issued == batch_len.
REQ-030 DRAIN SHALL go to DONE in the cycle after retired == batch_len (inflight=0).
REQ-031 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-032 stall_cnt SHALL increment on each cycle with out_valid && !out_ready while busy, and SHALL saturate at 16'hFFFF.
REQ-033 When flush=1 in any state, the next edge SHALL clear stage_valid and the counters and go to IDLE, without asserting done; flush SHALL take priority over start, accept and retire in the same cycle.
REQ-034 A back-pressure stall SHALL freeze the whole pipeline; no vector SHALL be dropped or duplicated.

Reset
REQ-035 While rst_n=0, state SHALL be IDLE and stage_valid, inflight, issued, retired, latched batch_len and stall_cnt SHALL all be 0.
REQ-036 While rst_n=0, busy=0, done=0, out_valid=0, in_ready=0 and pipe_en=1.
REQ-037 Reset asserted mid-batch SHALL abandon the batch with no done pulse.

Verification
REQ-038 batch_len=3, in_valid held 1, out_ready held 1 -> accepts on cycles 1..3; out_valid on cycles 8..10; done one cycle after the DRAIN exit; stall_cnt=0.
REQ-039 batch_len=2, out_ready=0 for 4 cycles once the first result appears -> pipe_en=0 and in_ready=0 during the stall; stage_valid frozen; stall_cnt=4; both results retired in order.
REQ-040 start with batch_len=0 -> DONE next cycle; done pulses once; no accept occurs.
REQ-041 flush during DRAIN with inflight=3 -> next cycle state IDLE, stage_valid=0, inflight=0, no done pulse.
REQ-042 rst_n asserted mid-FILL, then start with batch_len=1 -> outputs at reset values; the new batch completes normally with latency 7.
REQ-043 A simultaneous accept and retire in steady state -> inflight constant; pipeline full, 7 vectors in flight.
